fetch_stage: RTL and testbench

//  IF stage plus IF/ID pipeline register of the pipelined RV32I core; feeds ID (control, regfile, immgen).

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/imm_op_predecode.sv | 32 +++
 rtl/fetch_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encodings: major opcodes, one-hot immediate-format selects and the canonical NOP.
// Fetch, immgen and the main decoder all import this package.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [5:0] IMM_SHAMT = 6'b100000;
    localparam logic [5:0] IMM_I     = 6'b010000;
    localparam logic [5:0] IMM_S     = 6'b001000;
    localparam logic [5:0] IMM_B     = 6'b000100;
    localparam logic [5:0] IMM_U     = 6'b000010;
    localparam logic [5:0] IMM_J     = 6'b000001;
    localparam logic [5:0] IMM_NONE  = 6'b000000;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/imm_op_predecode.sv
// Combinational immediate-format predecode: picks the one-hot immgen select from opcode and funct3.
// Only opcode and funct3 matter; the remaining instruction bits are deliberately ignored.
module imm_op_predecode
    import riscv_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [5:0]  imm_op_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_bits;

    assign opcode      = instr_i[6:0];
    assign funct3      = instr_i[14:12];
    assign unused_bits = ^{instr_i[31:15], instr_i[11:7]};

    // Shift-immediates share OP-IMM but need the shamt field, so funct3 splits them off.
    always_comb begin
        imm_op_o = IMM_NONE;
        case (opcode)
            OPC_OP_IMM:          imm_op_o = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
            OPC_LOAD, OPC_JALR:  imm_op_o = IMM_I;
            OPC_STORE:           imm_op_o = IMM_S;
            OPC_BRANCH:          imm_op_o = IMM_B;
            OPC_LUI, OPC_AUIPC:  imm_op_o = IMM_U;
            OPC_JAL:             imm_op_o = IMM_J;
            default:             imm_op_o = IMM_NONE;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: single-outstanding instruction fetch with ID stall hold and EX redirect flush.
// A response that arrives while ID is stalled parks in a hold register until ID frees up.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr,
    output logic [5:0]  id_imm_op
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         discard_q, discard_d;
    logic [31:0]  hold_q, hold_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_pc_q, id_pc_d;
    logic [31:0]  id_pc_plus4_q, id_pc_plus4_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic [5:0]   id_imm_op_q, id_imm_op_d;

    logic [31:0]  pc_plus4;
    logic [31:0]  load_word;
    logic [5:0]   load_imm_op;
    logic         load;

    assign pc_plus4  = pc_q + 32'd4;
    assign load_word = (state_q == FETCH_HOLD) ? hold_q : imem_rdata;

    imm_op_predecode u_predecode (
        .instr_i  (load_word),
        .imm_op_o (load_imm_op)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        discard_d     = discard_q;
        hold_d        = hold_q;
        id_valid_d    = id_valid_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_instr_d    = id_instr_q;
        id_imm_op_d   = id_imm_op_q;
        load          = 1'b0;

        if (id_valid_q && !id_stall) begin
            id_valid_d = 1'b0;
        end

        case (state_q)
            FETCH_REQ: begin
                if (imem_req_ready) begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_resp_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = FETCH_REQ;
                    end else if (!id_valid_q || !id_stall) begin
                        load = 1'b1;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = FETCH_HOLD;
                    end
                end
            end
            FETCH_HOLD: begin
                if (!id_stall) begin
                    load = 1'b1;
                end
            end
            default: state_d = FETCH_REQ;
        endcase

        if (load) begin
            id_valid_d    = 1'b1;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            id_instr_d    = load_word;
            id_imm_op_d   = load_imm_op;
            pc_d          = pc_plus4;
            state_d       = FETCH_REQ;
        end

        // A request already in flight to the old path must have its response swallowed.
        if (redirect_valid) begin
            pc_d          = {redirect_pc[31:2], 2'b00};
            id_valid_d    = 1'b0;
            id_pc_d       = id_pc_q;
            id_pc_plus4_d = id_pc_plus4_q;
            id_instr_d    = NOP_INSTR;
            id_imm_op_d   = IMM_NONE;
            if ((state_q == FETCH_WAIT && !imem_resp_valid) ||
                (state_q == FETCH_REQ && imem_req_ready)) begin
                discard_d = 1'b1;
                state_d   = FETCH_WAIT;
            end else begin
                discard_d = 1'b0;
                state_d   = FETCH_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH_REQ;
            pc_q          <= {RESET_PC[31:2], 2'b00};
            discard_q     <= 1'b0;
            hold_q        <= 32'h0;
            id_valid_q    <= 1'b0;
            id_pc_q       <= 32'h0;
            id_pc_plus4_q <= 32'h0;
            id_instr_q    <= NOP_INSTR;
            id_imm_op_q   <= IMM_NONE;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            discard_q     <= discard_d;
            hold_q        <= hold_d;
            id_valid_q    <= id_valid_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_instr_q    <= id_instr_d;
            id_imm_op_q   <= id_imm_op_d;
        end
    end

    assign imem_req_valid = (state_q == FETCH_REQ) && !rst;
    assign imem_addr      = pc_q;
    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_pc_plus4    = id_pc_plus4_q;
    assign id_instr       = id_instr_q;
    assign id_imm_op      = id_imm_op_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run against a memory and program-order model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic [5:0]  id_imm_op;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_stall        (id_stall),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .id_instr        (id_instr),
        .id_imm_op       (id_imm_op)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus knobs and forced overrides
    int          readyPct, latMin, latMax, stallPct, redirPct;
    bit          forceStallEn, forceStallVal, forceRedirect, forceReady, doReset;
    logic [31:0] forceTarget;

    // Memory model: 64-word image, one pending request with a countdown
    logic [31:0] mem [0:63];
    bit          memPending;
    int          memCount;
    logic [31:0] memAddr;

    // Program-order model and observation logs
    logic [31:0] expPc;
    bit          checkFrozen, checkFlushed, prevReqStall;
    logic [31:0] prevAddr, savedPc, savedPc4, savedInstr;
    logic [5:0]  savedImm;
    logic [31:0] acceptQ[$];
    logic [31:0] consumedPcQ[$];
    logic [5:0]  consumedImmQ[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return mem[a[7:2]];
    endfunction

    // Immediate format chosen by the instruction class table
    function automatic logic [5:0] refImm(input logic [31:0] w);
        logic [6:0] opc = w[6:0];
        logic [2:0] f3  = w[14:12];
        case (opc)
            7'h13:        return (f3 == 3'd1 || f3 == 3'd5) ? 6'd32 : 6'd16;
            7'h03, 7'h67: return 6'd16;
            7'h23:        return 6'd8;
            7'h63:        return 6'd4;
            7'h37, 7'h17: return 6'd2;
            7'h6F:        return 6'd1;
            default:      return 6'd0;
        endcase
    endfunction

    // One clock: check last edge's consequences, drive inputs, predict the coming edge
    task automatic applyStimulus();
        bit          deliver;
        bit          accepted;
        logic [31:0] tgt;
        if (checkFrozen) begin
            checkOutput("stall_id_valid", 32'(id_valid), 32'd1);
            checkOutput("stall_id_pc", id_pc, savedPc);
            checkOutput("stall_id_pc_plus4", id_pc_plus4, savedPc4);
            checkOutput("stall_id_instr", id_instr, savedInstr);
            checkOutput("stall_id_imm_op", 32'(id_imm_op), 32'(savedImm));
            checkFrozen = 1'b0;
        end
        if (checkFlushed) begin
            checkOutput("flush_id_valid", 32'(id_valid), 32'd0);
            checkOutput("flush_id_instr", id_instr, NOP);
            checkOutput("flush_id_imm_op", 32'(id_imm_op), 32'd0);
            checkFlushed = 1'b0;
        end
        if (prevReqStall) begin
            checkOutput("req_held_valid", 32'(imem_req_valid), 32'd1);
            checkOutput("req_held_addr", imem_addr, prevAddr);
        end
        if (imem_req_valid === 1'b1) checkOutput("addr_align", 32'(imem_addr[1:0]), 32'd0);

        rst             = doReset;
        deliver         = memPending && memCount == 0;
        imem_resp_valid = deliver;
        imem_rdata      = deliver ? memWord(memAddr) : $urandom;
        imem_req_ready  = !memPending && (forceReady || int'($urandom_range(0, 99)) < readyPct);
        id_stall        = forceStallEn ? forceStallVal : (int'($urandom_range(0, 99)) < stallPct);
        redirect_valid  = !doReset && (forceRedirect || int'($urandom_range(0, 99)) < redirPct);
        tgt             = forceRedirect ? forceTarget : 32'($urandom_range(0, 255));
        redirect_pc     = tgt;
        #1;
        if (rst) checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);

        accepted = (imem_req_valid === 1'b1) && imem_req_ready;
        if (deliver) memPending = 1'b0;
        else if (memPending) memCount--;
        if (accepted) begin
            memPending = 1'b1;
            memCount   = int'($urandom_range(latMax, latMin)) - 1;
            memAddr    = imem_addr;
            acceptQ.push_back(imem_addr);
        end

        if (rst) begin
            expPc        = RESET_PC;
            prevReqStall = 1'b0;
        end else if (redirect_valid) begin
            expPc        = {tgt[31:2], 2'b00};
            checkFlushed = 1'b1;
            prevReqStall = 1'b0;
        end else begin
            if (id_valid === 1'b1 && !id_stall) begin
                checkOutput("id_pc", id_pc, expPc);
                checkOutput("id_pc_plus4", id_pc_plus4, expPc + 32'd4);
                checkOutput("id_instr", id_instr, memWord(expPc));
                checkOutput("id_imm_op", 32'(id_imm_op), 32'(refImm(memWord(expPc))));
                consumedPcQ.push_back(id_pc);
                consumedImmQ.push_back(id_imm_op);
                expPc = expPc + 32'd4;
            end else if (id_valid === 1'b1 && id_stall) begin
                savedPc     = id_pc;
                savedPc4    = id_pc_plus4;
                savedInstr  = id_instr;
                savedImm    = id_imm_op;
                checkFrozen = 1'b1;
            end
            prevReqStall = (imem_req_valid === 1'b1) && !imem_req_ready;
            prevAddr     = imem_addr;
        end
        @(negedge clk);
    endtask

    task automatic waitAccepts(input int n, input int budget, input string tag);
        int start = acceptQ.size();
        int cyc   = 0;
        while (acceptQ.size() < start + n && cyc < budget) begin
            applyStimulus();
            cyc++;
        end
        checkOutput(tag, 32'(acceptQ.size() - start), 32'(n));
    endtask

    task automatic waitConsumed(input int n, input int budget, input string tag);
        int start = consumedPcQ.size();
        int cyc   = 0;
        while (consumedPcQ.size() < start + n && cyc < budget) begin
            applyStimulus();
            cyc++;
        end
        checkOutput(tag, 32'(consumedPcQ.size() - start), 32'(n));
    endtask

    task automatic resetDut();
        doReset = 1'b1;
        applyStimulus();
        applyStimulus();
        doReset = 1'b0;
        acceptQ.delete();
        consumedPcQ.delete();
        consumedImmQ.delete();
    endtask

    task automatic fillRandomMem();
        logic [31:0] pool [0:7];
        pool[0] = 32'h00500093; pool[1] = 32'h123450B7; pool[2] = 32'h00112023; pool[3] = 32'h00000063;
        pool[4] = 32'h0000006F; pool[5] = 32'h00109093; pool[6] = 32'h001080B3; pool[7] = 32'h00012083;
        for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : $urandom;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] p;
        logic [31:0] addr0;
        int          startAcc;
        int          startCons;
        int          cyc;
        logic [5:0]  expImm [0:5];

        rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;
        forceStallEn = 0; forceStallVal = 0; forceRedirect = 0; forceReady = 0; doReset = 0;
        forceTarget = 32'h0; memPending = 0; memCount = 0; memAddr = 32'h0; expPc = RESET_PC;
        checkFrozen = 0; checkFlushed = 0; prevReqStall = 0; prevAddr = 32'h0;
        readyPct = 100; latMin = 1; latMax = 1; stallPct = 0; redirPct = 0;
        @(negedge clk);

        $display("[TB] reset state and 1-cycle memory streaming addi");
        for (int i = 0; i < 64; i++) mem[i] = 32'h00500093;
        resetDut();
        checkOutput("reset_id_valid", 32'(id_valid), 32'd0);
        checkOutput("reset_id_pc", id_pc, 32'h0);
        checkOutput("reset_id_pc_plus4", id_pc_plus4, 32'h0);
        checkOutput("reset_id_instr", id_instr, NOP);
        checkOutput("reset_id_imm_op", 32'(id_imm_op), 32'd0);
        checkOutput("reset_imem_addr", imem_addr, RESET_PC);
        checkOutput("reset_req_valid", 32'(imem_req_valid), 32'd0);
        waitAccepts(3, 30, "t1_accept_count");
        if (acceptQ.size() >= 3) begin
            checkOutput("t1_addr0", acceptQ[0], 32'h0);
            checkOutput("t1_addr1", acceptQ[1], 32'h4);
            checkOutput("t1_addr2", acceptQ[2], 32'h8);
        end
        waitConsumed(1, 10, "t1_consume_count");
        if (consumedPcQ.size() >= 1) begin
            checkOutput("t1_first_pc", consumedPcQ[0], 32'h0);
            checkOutput("t1_first_imm", 32'(consumedImmQ[0]), 32'b010000);
        end

        $display("[TB] predecode stream lui/sw/beq/jal/slli/add");
        for (int i = 0; i < 64; i++) mem[i] = NOP;
        mem[0] = 32'h123450B7; mem[1] = 32'h00112023; mem[2] = 32'h00000063;
        mem[3] = 32'h0000006F; mem[4] = 32'h00109093; mem[5] = 32'h001080B3;
        expImm[0] = 6'b000010; expImm[1] = 6'b001000; expImm[2] = 6'b000100;
        expImm[3] = 6'b000001; expImm[4] = 6'b100000; expImm[5] = 6'b000000;
        resetDut();
        waitConsumed(6, 60, "t2_consume_count");
        if (consumedImmQ.size() >= 6)
            for (int i = 0; i < 6; i++) checkOutput($sformatf("t2_imm_%0d", i), 32'(consumedImmQ[i]), 32'(expImm[i]));

        $display("[TB] ID stall with a response pending");
        fillRandomMem();
        resetDut();
        cyc = 0;
        while (id_valid !== 1'b1 && cyc < 20) begin applyStimulus(); cyc++; end
        checkOutput("t3_got_valid", 32'(id_valid), 32'd1);
        p = id_pc;
        forceStallEn = 1; forceStallVal = 1;
        startAcc = acceptQ.size();
        repeat (4) applyStimulus();
        checkOutput("t3_hold_no_req", 32'(imem_req_valid), 32'd0);
        checkOutput("t3_one_req", 32'(acceptQ.size() - startAcc), 32'd1);
        forceStallVal = 0;
        applyStimulus();
        forceStallEn = 0;
        checkOutput("t3_release_valid", 32'(id_valid), 32'd1);
        checkOutput("t3_release_pc", id_pc, p + 32'd4);

        $display("[TB] redirect while waiting on memory");
        latMin = 3; latMax = 3;
        waitAccepts(1, 20, "t4_accept_before");
        forceRedirect = 1; forceTarget = 32'h0000_0102;
        applyStimulus();
        forceRedirect = 0;
        checkOutput("t4_flush_valid", 32'(id_valid), 32'd0);
        startAcc  = acceptQ.size();
        startCons = consumedPcQ.size();
        waitAccepts(1, 20, "t4_accept_after");
        if (acceptQ.size() > startAcc) checkOutput("t4_new_addr", acceptQ[startAcc], 32'h100);
        waitConsumed(1, 20, "t4_consume_after");
        if (consumedPcQ.size() > startCons) checkOutput("t4_first_pc", consumedPcQ[startCons], 32'h100);

        $display("[TB] backpressure then redirect on accept");
        readyPct = 0; latMin = 2; latMax = 2;
        cyc = 0;
        while (!(imem_req_valid === 1'b1 && !memPending) && cyc < 30) begin applyStimulus(); cyc++; end
        addr0 = imem_addr;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t5_req_valid_%0d", i), 32'(imem_req_valid), 32'd1);
            checkOutput($sformatf("t5_addr_%0d", i), imem_addr, addr0);
            applyStimulus();
        end
        forceReady = 1; forceRedirect = 1; forceTarget = 32'h0000_0040;
        startAcc = acceptQ.size();
        applyStimulus();
        forceReady = 0; forceRedirect = 0; readyPct = 100;
        checkOutput("t5_old_accept_count", 32'(acceptQ.size() - startAcc), 32'd1);
        if (acceptQ.size() > startAcc) checkOutput("t5_old_accept_addr", acceptQ[startAcc], addr0);
        startAcc  = acceptQ.size();
        startCons = consumedPcQ.size();
        waitAccepts(1, 20, "t5_accept_after");
        if (acceptQ.size() > startAcc) checkOutput("t5_new_addr", acceptQ[startAcc], 32'h40);
        waitConsumed(1, 20, "t5_consume_after");
        if (consumedPcQ.size() > startCons) checkOutput("t5_first_pc", consumedPcQ[startCons], 32'h40);

        $display("[TB] PC wrap and reset while waiting");
        latMin = 1; latMax = 1;
        forceRedirect = 1; forceTarget = 32'hFFFF_FFFE;
        applyStimulus();
        forceRedirect = 0;
        startAcc = acceptQ.size();
        waitAccepts(2, 30, "t6_wrap_accepts");
        if (acceptQ.size() >= startAcc + 2) begin
            checkOutput("t6_wrap_addr0", acceptQ[startAcc], 32'hFFFF_FFFC);
            checkOutput("t6_wrap_addr1", acceptQ[startAcc + 1], 32'h0);
        end
        latMin = 3; latMax = 3;
        waitAccepts(1, 20, "t6_accept_before_rst");
        doReset = 1;
        applyStimulus();
        doReset = 0;
        checkOutput("t6_rst_id_valid", 32'(id_valid), 32'd0);
        checkOutput("t6_rst_addr", imem_addr, RESET_PC);
        startCons = consumedPcQ.size();
        waitConsumed(1, 30, "t6_consume_after_rst");
        if (consumedPcQ.size() > startCons) checkOutput("t6_first_pc", consumedPcQ[startCons], RESET_PC);

        $display("[TB] randomized traffic");
        fillRandomMem();
        readyPct = 70; latMin = 1; latMax = 3; stallPct = 30; redirPct = 5;
        startCons = consumedPcQ.size();
        repeat (3000) applyStimulus();
        checkOutput("rand_progress", 32'(consumedPcQ.size() - startCons > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
